fir_coef_loader: RTL and testbench

Writer side of the FIR coefficient interface. Accepts coefficients one word per handshake on a valid/ready stream and collects them in a shadow bank. After the last tap is written, it commits the whole bank atomically to the packed `coefs` bus that drives the FIR filter. The filter therefore never sees a partially loaded coefficient set, and can keep running while a new set is streamed in.

---
 rtl/fir_coef_loader.sv | 97 +++++++++
 tb/tb_fir_coef_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// Shadow-bank coefficient loader for the FIR filter.
// Streams taps in over valid/ready and then swaps the full set onto `coefs` in one edge.
module fir_coef_loader #(
    parameter  int REGS_NUM = 2,
    parameter  int COEF_SZ  = 16,
    localparam int TAP_W    = (REGS_NUM > 1) ? $clog2(REGS_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic                    in_valid,
    input  logic [COEF_SZ-1:0]      in_data,
    output logic                    in_ready,
    output logic [REGS_NUM*32-1:0]  coefs,
    output logic                    busy,
    output logic                    done,
    output logic [TAP_W-1:0]        tap_idx
);

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(REGS_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                     r_state;
    logic signed [COEF_SZ-1:0]  r_shadow [REGS_NUM];
    logic [REGS_NUM*32-1:0]     r_coefs;
    logic                       r_done;
    logic [TAP_W-1:0]           r_tap_idx;
    logic [REGS_NUM*32-1:0]     w_packed;

    function automatic logic [31:0] sext32(input logic signed [COEF_SZ-1:0] c);
        return 32'(c);
    endfunction

    // Tap 0 lands in the most significant slot of the packed bus.
    always_comb begin
        w_packed = '0;
        for (int i = 0; i < REGS_NUM; i++) begin
            w_packed[(REGS_NUM-1-i)*32 +: 32] = sext32(r_shadow[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_coefs   <= '0;
            r_done    <= 1'b0;
            r_tap_idx <= '0;
            for (int i = 0; i < REGS_NUM; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_state   <= S_LOAD;
                        r_tap_idx <= '0;
                    end
                end
                S_LOAD: begin
                    // A restart wins over a word presented in the same cycle.
                    if (load_start) begin
                        r_tap_idx <= '0;
                    end else if (in_valid) begin
                        r_shadow[r_tap_idx] <= in_data;
                        if (r_tap_idx == LAST_TAP) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_tap_idx <= r_tap_idx + TAP_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    r_coefs   <= w_packed;
                    r_done    <= 1'b1;
                    r_tap_idx <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign coefs    = r_coefs;
    assign done     = r_done;
    assign tap_idx  = r_tap_idx;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Scoreboard bench for fir_coef_loader (4 taps, 16-bit coefficients).
// Expected coefficient sets are queued at stimulus time and popped on every done pulse.
module tb_fir_coef_loader;

    localparam int RN = 4;
    localparam int CS = 16;

    localparam logic [127:0] SA = 128'h00000001_FFFFFFFE_00007FFF_FFFF8000;
    localparam logic [63:0]  WA = 64'h0001_FFFE_7FFF_8000;
    localparam logic [127:0] SB = 128'h00000005_00000006_00000007_00000008;
    localparam logic [63:0]  WB = 64'h0005_0006_0007_0008;
    localparam logic [127:0] SC = 128'h00000001_00000002_00000003_00000004;
    localparam logic [63:0]  WC = 64'h0001_0002_0003_0004;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [CS-1:0] in_data = '0;
    logic          in_ready;
    logic [127:0]  coefs;
    logic          busy;
    logic          done;
    logic [1:0]    tap_idx;

    int            checks = 0;
    int            failures = 0;
    int            busy_cnt = 0;
    logic [127:0]  sb[$];
    logic [127:0]  sb_exp;

    fir_coef_loader #(.REGS_NUM(RN), .COEF_SZ(CS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .coefs      (coefs),
        .busy       (busy),
        .done       (done),
        .tap_idx    (tap_idx)
    );

    always #5 clk = ~clk;

    task automatic checkv(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued set.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check1("unexpected_done", done, 1'b0);
            end else begin
                sb_exp = sb.pop_front();
                checkv("sb_coefs", coefs, sb_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_words(input logic [63:0] ws, input int n, input int gap,
                              input logic [127:0] hold);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = ws[63-16*i -: 16];
            tick();
            in_valid = 1'b0;
            in_data  = '0;
            if (gap > 0 && i < n - 1) begin
                repeat (gap) begin
                    checkv("gap_tap_idx", 128'(tap_idx), 128'(i + 1));
                    checkv("gap_coefs_hold", coefs, hold);
                    tick();
                end
            end
        end
    endtask

    task automatic finish_commit(input logic [127:0] exp);
        check1("commit_done_low", done, 1'b0);
        check1("commit_busy", busy, 1'b1);
        check1("commit_in_ready", in_ready, 1'b0);
        tick();
        check1("done_pulse", done, 1'b1);
        checkv("coefs_after_commit", coefs, exp);
        check1("done_cycle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkv("rst_coefs", coefs, '0);
        check1("rst_done", done, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_busy", busy, 1'b0);
        checkv("rst_tap_idx", 128'(tap_idx), '0);
        rst_n = 1'b1;
        tick();

        // Basic load with in_valid held high
        sb.push_back(SA);
        busy_cnt = 0;
        do_start();
        check1("load_in_ready", in_ready, 1'b1);
        checkv("load_tap_idx", 128'(tap_idx), '0);
        send_words(WA, 4, 0, '0);
        finish_commit(SA);
        checkv("busy_cycles", 128'(busy_cnt), 128'(5));
        tick();
        check1("done_one_cycle", done, 1'b0);

        // Restart after two words; the word alongside load_start is dropped
        sb.push_back(SB);
        do_start();
        send_words(WA, 2, 0, SA);
        checkv("pre_restart_tap_idx", 128'(tap_idx), 128'(2));
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 16'h1234;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        checkv("restart_tap_idx", 128'(tap_idx), '0);
        check1("restart_in_ready", in_ready, 1'b1);
        checkv("restart_coefs_hold", coefs, SA);
        send_words(WB, 4, 0, SA);
        finish_commit(SB);

        // Backpressure gaps
        sb.push_back(SA);
        do_start();
        send_words(WA, 4, 3, SB);
        finish_commit(SA);

        // Traffic while idle is ignored
        tick();
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        repeat (3) begin
            check1("idle_in_ready", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkv("idle_coefs", coefs, SA);
        checkv("idle_tap_idx", 128'(tap_idx), '0);
        check1("idle_busy", busy, 1'b0);

        // Reset in the middle of a load
        do_start();
        send_words(WB, 3, 0, SA);
        rst_n = 1'b0;
        #2;
        checkv("midrst_coefs", coefs, '0);
        check1("midrst_done", done, 1'b0);
        check1("midrst_in_ready", in_ready, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        checkv("midrst_tap_idx", 128'(tap_idx), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkv("post_rst_coefs", coefs, '0);
        sb.push_back(SC);
        do_start();
        send_words(WC, 4, 0, '0);
        load_start = 1'b1;
        finish_commit(SC);
        load_start = 1'b0;
        check1("commit_start_ignored", in_ready, 1'b0);

        // Back-to-back: restart in the done cycle
        tick();
        sb.push_back(SA);
        do_start();
        send_words(WA, 4, 0, SC);
        finish_commit(SA);
        sb.push_back(SB);
        do_start();
        check1("b2b_in_ready", in_ready, 1'b1);
        send_words(WB, 4, 0, SA);
        finish_commit(SB);

        tick();
        tick();
        checkv("sb_empty", 128'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
